mem_bus_ctrl: RTL and testbench
===============================

# mem_bus_ctrl

Data-bus access controller for the MEM stage of the five-stage MIPS pipeline. It accepts a single load/store request from MEM and runs one transaction on a word-wide ready/ack data bus with wait states. It holds the pipeline via `stallreq` until the transaction completes, then returns aligned, extended load data or an error code. It sits between MEM and the data-memory port; results feed the MEM→WB path.

## Interface
Parameters:
- `TIMEOUT`, 255: max WAIT cycles without ack before abort; ≥1.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: MEM holds a load/store; must stay stable while `stallreq`=1.
- `req_we` in 1: 1 store, 0 load.
- `req_size` in 2: 00 byte, 01 half, 10 word; 11 treated as word.
- `req_signed` in 1: sign-extend loads (LB/LH); 0 zero-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `flush` in 1: discard the current access result.
- `stallreq` out 1: stall request to pipeline controller.
- `resp_valid` out 1: one-cycle pulse, access finished.
- `resp_rdata` out 32: extended load data; 0 for stores or errors.
- `resp_err` out 2: 00 ok, 01 misaligned, 10 bus error, 11 timeout.
- `bus_req` out 1: transaction active.
- `bus_we` out 1: write.
- `bus_addr` out 32: word address, {req_addr[31:2],2'b00}.
- `bus_sel` out 4: byte lane enables, big-endian.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_ack` in 1: transfer done this cycle.
- `bus_err` in 1: transfer failed this cycle; wins over ack.
- `bus_rdata` in 32: read data, valid with ack.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE, `req_valid`=1 and `flush`=0:
  - Aligned: register the bus outputs, go to WAIT.
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠0): no bus cycle; go to DONE with err=01.
- WAIT: `bus_req`=1 with all bus outputs held.
  - `bus_err` → DONE, err=10.
  - `bus_ack` → capture lane data, DONE, err=00.
  - Timeout counter reaches TIMEOUT with no ack/err → drop `bus_req`, DONE, err=11.
- DONE: `resp_valid`=1 unless discard flag set, then → IDLE. `req_valid` is ignored in DONE; the same instruction advances.
- Big-endian lanes: byte offset 0 → sel 1000, data[31:24]; offset 3 → sel 0001. Half offset 0 → sel 1100; offset 2 → sel 0011. Word → 1111.
- Stores: byte replicated ×4, half replicated ×2.
- Loads: selected lane right-justified, then sign- or zero-extended per `req_signed`.
- `flush` handling:
  - In IDLE: request dropped.
  - In WAIT: sets the discard flag. The bus cycle still completes (never abandoned), and DONE suppresses `resp_valid`.
  - Discard flag clears in IDLE.
- `stallreq` = (IDLE & req_valid & ~flush) | WAIT. It is 0 in DONE.

## Timing
- Reset edge: state IDLE; all outputs 0 (`stallreq`, `resp_valid`, `resp_rdata`, `resp_err`, `bus_*`); counter and discard flag 0.
- Reset mid-WAIT: `bus_req` low the cycle after the reset edge. The bus slave must tolerate the abort.
- Aligned access latency: IDLE(accept) → WAIT ≥1 cycle → DONE. Minimum 3 cycles, with ack in the first WAIT cycle.
- Misaligned access: 2 cycles, IDLE → DONE.
- Timeout: exactly TIMEOUT WAIT cycles, then DONE.
- `resp_rdata`/`resp_err` are registered. They are valid only while `resp_valid`=1 and are held until the next DONE.
- Ack and err in the same cycle: err wins.
- Ack in the final timeout cycle: ack wins.

## Structure
- Add to `defines.v`: size codes (`SizeByte`/`SizeHalf`/`SizeWord`), error codes, FSM state encodings.
- Sub-module `mem_lane_align` (combinational):
  - addr[1:0] + size → sel.
  - Store data replication.
  - Load lane extract/extend.
  - Misalign detect.
- FSM, timeout counter, discard flag and registers stay in `mem_bus_ctrl`.

## Test plan
- LW addr 0x100, ack on first WAIT cycle, rdata 0xDEADBEEF → bus_sel 1111, resp_valid at cycle 3, resp_rdata 0xDEADBEEF, err 00.
- LB signed addr 0x103, rdata 0x000000F0, ack after 4 wait cycles → sel 0001, resp_rdata 0xFFFFFFF0; LBU same → 0x000000F0; stallreq high all 5 pre-DONE cycles.
- SH addr 0x202 wdata 0x0000ABCD → bus_we 1, sel 0011, bus_wdata 0xABCDABCD; SB addr 0x200 data 0x7E → sel 1000, wdata 0x7E7E7E7E.
- LW addr 0x101 → no bus_req, resp_valid cycle 2, err 01; LH addr 0x101 → err 01.
- TIMEOUT=4, ack never asserted → bus_req for exactly 4 cycles, then err 11; separately, bus_err on cycle 2 → err 10, rdata 0.
- Flush during WAIT, ack 2 cycles later → transaction completes, resp_valid stays 0, back to IDLE; rst asserted mid-WAIT → all outputs 0 next cycle.

Source files
------------

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared codes for the MEM-stage data-bus controller:
// access sizes, response error codes and FSM state encodings.
package mem_bus_ctrl_pkg;

  localparam logic [1:0] SizeByte = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeWord = 2'b10;

  localparam logic [1:0] ErrOk       = 2'b00;
  localparam logic [1:0] ErrMisalign = 2'b01;
  localparam logic [1:0] ErrBus      = 2'b10;
  localparam logic [1:0] ErrTimeout  = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StDone = 2'b10
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane logic: off/size -> sel, store replication,
// load lane extract + extend, misalignment detect. Purely combinational.
module mem_lane_align
  import mem_bus_ctrl_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic is_byte;
  logic is_half;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign is_byte = (size == SizeByte);
  assign is_half = (size == SizeHalf);

  always_comb begin
    lane_b = 8'h00;
    unique case (off)
      2'd0: lane_b = rdata[31:24];
      2'd1: lane_b = rdata[23:16];
      2'd2: lane_b = rdata[15:8];
      2'd3: lane_b = rdata[7:0];
      default: lane_b = 8'h00;
    endcase
    lane_h = off[1] ? rdata[15:0] : rdata[31:16];
  end

  // Size code 11 falls into the word arm.
  always_comb begin
    sel        = 4'b1111;
    wdata_rep  = wdata;
    rdata_ext  = rdata;
    misaligned = 1'b0;
    unique case (1'b1)
      is_byte: begin
        sel       = 4'b1000 >> off;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sgn & lane_b[7]}}, lane_b};
      end
      is_half: begin
        sel        = off[1] ? 4'b0011 : 4'b1100;
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = {{16{sgn & lane_h[15]}}, lane_h};
        misaligned = off[0];
      end
      default: misaligned = (off != 2'b00);
    endcase
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// MEM-stage load/store bus controller: one ready/ack transaction per request,
// stalls the pipe until done, returns extended load data or an error code.
// Ports: req_* from MEM, stallreq/resp_* back, bus_* to data memory.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        stallreq,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        disc_q, disc_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic        breq_q, breq_d;
  logic        bwe_q, bwe_d;
  logic [31:0] baddr_q, baddr_d;
  logic [3:0]  bsel_q, bsel_d;
  logic [31:0] bwdata_q, bwdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;

  logic        idle;
  logic [1:0]  al_off;
  logic [1:0]  al_size;
  logic        al_sgn;
  logic [3:0]  al_sel;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        al_mis;

  assign idle = (state_q == StIdle);

  // Live request fields while accepting; the latched copy afterwards.
  assign al_off  = idle ? req_addr[1:0] : off_q;
  assign al_size = idle ? req_size : size_q;
  assign al_sgn  = idle ? req_signed : sgn_q;

  mem_lane_align u_align (
    .off        (al_off),
    .size       (al_size),
    .sgn        (al_sgn),
    .wdata      (req_wdata),
    .rdata      (bus_rdata),
    .sel        (al_sel),
    .wdata_rep  (al_wdata),
    .rdata_ext  (al_rdata),
    .misaligned (al_mis)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    disc_d   = disc_q;
    off_d    = off_q;
    size_d   = size_q;
    sgn_d    = sgn_q;
    breq_d   = breq_q;
    bwe_d    = bwe_q;
    baddr_d  = baddr_q;
    bsel_d   = bsel_q;
    bwdata_d = bwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        disc_d = 1'b0;
        cnt_d  = '0;
        if (req_valid && !flush) begin
          off_d  = req_addr[1:0];
          size_d = req_size;
          sgn_d  = req_signed;
          if (al_mis) begin
            state_d = StDone;
            err_d   = ErrMisalign;
            rdata_d = '0;
          end else begin
            state_d  = StWait;
            breq_d   = 1'b1;
            bwe_d    = req_we;
            baddr_d  = {req_addr[31:2], 2'b00};
            bsel_d   = al_sel;
            bwdata_d = al_wdata;
          end
        end
      end
      StWait: begin
        // A flushed access still runs to completion on the bus.
        if (flush) disc_d = 1'b1;
        if (bus_err || bus_ack || cnt_q == CntLast) begin
          state_d  = StDone;
          cnt_d    = '0;
          breq_d   = 1'b0;
          bwe_d    = 1'b0;
          baddr_d  = '0;
          bsel_d   = '0;
          bwdata_d = '0;
          rdata_d  = '0;
          if (bus_err) begin
            err_d = ErrBus;
          end else if (bus_ack) begin
            err_d = ErrOk;
            if (!bwe_q) rdata_d = al_rdata;
          end else begin
            err_d = ErrTimeout;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      disc_q   <= 1'b0;
      off_q    <= '0;
      size_q   <= '0;
      sgn_q    <= 1'b0;
      breq_q   <= 1'b0;
      bwe_q    <= 1'b0;
      baddr_q  <= '0;
      bsel_q   <= '0;
      bwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      disc_q   <= disc_d;
      off_q    <= off_d;
      size_q   <= size_d;
      sgn_q    <= sgn_d;
      breq_q   <= breq_d;
      bwe_q    <= bwe_d;
      baddr_q  <= baddr_d;
      bsel_q   <= bsel_d;
      bwdata_q <= bwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign stallreq   = (idle && req_valid && !flush)
                    || (state_q == StWait);
  assign resp_valid = (state_q == StDone) && !disc_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign bus_req    = breq_q;
  assign bus_we     = bwe_q;
  assign bus_addr   = baddr_q;
  assign bus_sel    = bsel_q;
  assign bus_wdata  = bwdata_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl (TIMEOUT=4): loads, stores,
// misalignment, bus error, timeout, flush and reset cases.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic        stallreq;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic        bus_err;
  logic [31:0] bus_rdata;

  int tests = 0;
  int fails = 0;

  logic [105:0] all_out;
  assign all_out = {stallreq, resp_valid, resp_rdata, resp_err,
                    bus_req, bus_we, bus_addr, bus_sel, bus_wdata};

  always #5 clk = ~clk;

  mem_bus_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .flush(flush), .stallreq(stallreq),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_sel(bus_sel), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_err(bus_err),
    .bus_rdata(bus_rdata)
  );

  // Observations from the most recent access.
  int          o_done, o_resp, o_nresp, o_stall, o_breq, o_unst;
  logic        o_we;
  logic [31:0] o_addr, o_wdata, o_rdata;
  logic [3:0]  o_sel;
  logic [1:0]  o_err;

  // Drives one request and acts as bus slave. ack_at/err_at/flush_at
  // name the WAIT cycle (1-based) for that event; 0 means never.
  task automatic do_access(input logic we, input logic [1:0] size,
                           input logic sgn, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int ack_at, input int err_at,
                           input int flush_at);
    int wi;
    wi = 0;
    o_done = 0; o_resp = 0; o_nresp = 0;
    o_stall = 0; o_breq = 0; o_unst = 0;
    o_we = 1'bx; o_addr = 'x; o_wdata = 'x;
    o_sel = 'x; o_rdata = 'x; o_err = 'x;
    req_valid = 1'b1; req_we = we; req_size = size;
    req_signed = sgn; req_addr = addr; req_wdata = wd;
    for (int c = 1; c <= 20 && o_done == 0; c++) begin
      if (bus_req) wi++;
      bus_ack   = bus_req && (wi == ack_at);
      bus_err   = bus_req && (wi == err_at);
      flush     = bus_req && (wi == flush_at);
      bus_rdata = rd;
      @(negedge clk);
      if (stallreq) o_stall++;
      if (bus_req) begin
        o_breq++;
        if (o_breq == 1) begin
          o_we = bus_we; o_addr = bus_addr;
          o_sel = bus_sel; o_wdata = bus_wdata;
        end else if ({bus_we, bus_addr, bus_sel, bus_wdata}
                     !== {o_we, o_addr, o_sel, o_wdata}) begin
          o_unst++;
        end
      end
      if (resp_valid) begin
        o_nresp++; o_resp = c;
        o_rdata = resp_rdata; o_err = resp_err;
      end
      if (c > 1 && !stallreq) o_done = c;
      @(posedge clk); #1;
      bus_ack = 1'b0; bus_err = 1'b0; flush = 1'b0;
    end
    req_valid = 1'b0; req_we = 1'b0;
    if (o_done == 0) begin
      tests++; fails++;
      $display("FAIL access_timeout: no completion in 20 cycles");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    tests++;
    if (all_out !== 106'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_lw();
    do_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 0, 0);
    tests++;
    if (o_sel !== 4'b1111 || o_addr !== 32'h100 || o_we !== 1'b0) begin
      fails++;
      $display("FAIL lw_bus: sel %b addr %h we %b want 1111 100 0",
               o_sel, o_addr, o_we);
    end
    tests++;
    if (o_resp !== 3 || o_nresp !== 1 || o_stall !== 2) begin
      fails++;
      $display("FAIL lw_timing: resp@%0d n%0d stall%0d want 3 1 2",
               o_resp, o_nresp, o_stall);
    end
    tests++;
    if (o_rdata !== 32'hDEADBEEF || o_err !== 2'b00) begin
      fails++;
      $display("FAIL lw_data: %h err %b want deadbeef 00", o_rdata, o_err);
    end
  endtask

  task automatic test_lb();
    // Ack in the 4th WAIT cycle, which is also the last timeout cycle.
    do_access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h000000F0, 4, 0, 0);
    tests++;
    if (o_sel !== 4'b0001 || o_addr !== 32'h100 || o_unst !== 0) begin
      fails++;
      $display("FAIL lb_bus: sel %b addr %h unst %0d want 0001 100 0",
               o_sel, o_addr, o_unst);
    end
    tests++;
    if (o_stall !== 5 || o_breq !== 4 || o_resp !== 6) begin
      fails++;
      $display("FAIL lb_timing: stall%0d breq%0d resp@%0d want 5 4 6",
               o_stall, o_breq, o_resp);
    end
    tests++;
    if (o_rdata !== 32'hFFFFFFF0 || o_err !== 2'b00) begin
      fails++;
      $display("FAIL lb_data: %h err %b want fffffff0 00", o_rdata, o_err);
    end
    do_access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h000000F0, 4, 0, 0);
    tests++;
    if (o_rdata !== 32'h000000F0 || o_err !== 2'b00) begin
      fails++;
      $display("FAIL lbu_data: %h err %b want 000000f0 00", o_rdata, o_err);
    end
  endtask

  task automatic test_lh();
    do_access(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'h12348001, 1, 0, 0);
    tests++;
    if (o_sel !== 4'b0011 || o_rdata !== 32'hFFFF8001) begin
      fails++;
      $display("FAIL lh_data: sel %b data %h want 0011 ffff8001",
               o_sel, o_rdata);
    end
    do_access(1'b0, 2'b11, 1'b0, 32'h104, 32'h0, 32'hCAFE0001, 1, 0, 0);
    tests++;
    if (o_sel !== 4'b1111 || o_rdata !== 32'hCAFE0001) begin
      fails++;
      $display("FAIL size11_word: sel %b data %h want 1111 cafe0001",
               o_sel, o_rdata);
    end
  endtask

  task automatic test_store();
    do_access(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000ABCD, 32'h11111111, 1, 0, 0);
    tests++;
    if (o_we !== 1'b1 || o_sel !== 4'b0011 || o_wdata !== 32'hABCDABCD
        || o_addr !== 32'h200) begin
      fails++;
      $display("FAIL sh_bus: we %b sel %b wd %h addr %h want 1 0011 abcdabcd 200",
               o_we, o_sel, o_wdata, o_addr);
    end
    tests++;
    if (o_rdata !== 32'h0 || o_err !== 2'b00 || o_resp !== 3) begin
      fails++;
      $display("FAIL sh_resp: %h err %b @%0d want 0 00 3",
               o_rdata, o_err, o_resp);
    end
    do_access(1'b1, 2'b00, 1'b0, 32'h200, 32'h1234567E, 32'h0, 1, 0, 0);
    tests++;
    if (o_sel !== 4'b1000 || o_wdata !== 32'h7E7E7E7E) begin
      fails++;
      $display("FAIL sb_bus: sel %b wd %h want 1000 7e7e7e7e",
               o_sel, o_wdata);
    end
  endtask

  task automatic test_misalign();
    do_access(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h55555555, 1, 0, 0);
    tests++;
    if (o_breq !== 0 || o_resp !== 2 || o_err !== 2'b01
        || o_rdata !== 32'h0) begin
      fails++;
      $display("FAIL lw_misalign: breq%0d @%0d err %b d %h want 0 2 01 0",
               o_breq, o_resp, o_err, o_rdata);
    end
    do_access(1'b0, 2'b01, 1'b0, 32'h101, 32'h0, 32'h55555555, 1, 0, 0);
    tests++;
    if (o_breq !== 0 || o_err !== 2'b01) begin
      fails++;
      $display("FAIL lh_misalign: breq%0d err %b want 0 01", o_breq, o_err);
    end
  endtask

  task automatic test_errors();
    do_access(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h12345678, 0, 0, 0);
    tests++;
    if (o_breq !== 4 || o_err !== 2'b11 || o_resp !== 6
        || o_rdata !== 32'h0) begin
      fails++;
      $display("FAIL timeout: breq%0d err %b @%0d d %h want 4 11 6 0",
               o_breq, o_err, o_resp, o_rdata);
    end
    do_access(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h12345678, 0, 2, 0);
    tests++;
    if (o_err !== 2'b10 || o_rdata !== 32'h0 || o_resp !== 4) begin
      fails++;
      $display("FAIL bus_err: err %b d %h @%0d want 10 0 4",
               o_err, o_rdata, o_resp);
    end
    do_access(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h12345678, 1, 1, 0);
    tests++;
    if (o_err !== 2'b10 || o_rdata !== 32'h0) begin
      fails++;
      $display("FAIL err_wins: err %b d %h want 10 0", o_err, o_rdata);
    end
  endtask

  task automatic test_flush();
    do_access(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h9ABCDEF0, 3, 0, 1);
    tests++;
    if (o_nresp !== 0 || o_breq !== 3 || o_done !== 5) begin
      fails++;
      $display("FAIL flush_wait: nresp%0d breq%0d done@%0d want 0 3 5",
               o_nresp, o_breq, o_done);
    end
    @(negedge clk);
    tests++;
    if ({stallreq, resp_valid, bus_req} !== 3'b000) begin
      fails++;
      $display("FAIL flush_idle: got %b want 000",
               {stallreq, resp_valid, bus_req});
    end
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10;
    req_addr = 32'h500; flush = 1'b1;
    @(negedge clk);
    tests++;
    if (stallreq !== 1'b0) begin
      fails++;
      $display("FAIL flush_idle_stall: got %b want 0", stallreq);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    tests++;
    if ({bus_req, resp_valid} !== 2'b00) begin
      fails++;
      $display("FAIL flush_idle_drop: got %b want 00", {bus_req, resp_valid});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    do_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 0, 0);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
    req_addr = 32'h108; req_wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if (bus_req !== 1'b1 || bus_wdata !== 32'hA5A5A5A5) begin
      fails++;
      $display("FAIL rst_wait_setup: req %b wd %h want 1 a5a5a5a5",
               bus_req, bus_wdata);
    end
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (all_out !== 106'd0) begin
      fails++;
      $display("FAIL rst_mid_wait: got %h want 0", all_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_access(1'b0, 2'b00, 1'b0, 32'h601, 32'h0, 32'h11AA2233, 1, 0, 0);
    do_access(1'b0, 2'b01, 1'b0, 32'h600, 32'h0, 32'h8001FFFF, 2, 0, 0);
    tests++;
    if (o_rdata !== 32'h00008001 || o_sel !== 4'b1100 || o_resp !== 4) begin
      fails++;
      $display("FAIL b2b_lhu: d %h sel %b @%0d want 00008001 1100 4",
               o_rdata, o_sel, o_resp);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0; flush = 1'b0;
    bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = '0;
    test_reset();
    test_lw();
    test_lb();
    test_lh();
    test_store();
    test_misalign();
    test_errors();
    test_flush();
    test_reset_mid_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
